// File: rtl/mem_access_master.sv
// Initiator for the word-indexed main-memory port: one outstanding load/store at a time,
// registered memory strobes and a registered valid/ready response channel.
module mem_access_master #(
   parameter int unsigned MEM_DEPTH    = 8192,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWData,
   output logic        respValid,
   input  logic        respReady,
   output logic [31:0] respRData,
   output logic        respError,
   output logic [31:0] memAddress,
   output logic        memReadEnable,
   output logic        memWriteEnable,
   output logic [31:0] memDataIn,
   input  logic [31:0] memDataOut,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_error_q, resp_error_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic        mem_re_q, mem_re_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_din_q, mem_din_d;
   logic        busy_q, busy_d;

   logic [31:0] word_idx;
   logic        req_err;

   // Full 32-bit index compare so high addresses never wrap into range.
   assign word_idx = reqAddr >> 2;
   assign req_err  = (reqAddr[1:0] != 2'b00) || (word_idx >= MEM_DEPTH);

   // Next-state and registered-output computation.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      resp_rdata_d  = resp_rdata_q;
      resp_error_d  = resp_error_q;
      mem_address_d = mem_address_q;
      mem_din_d     = mem_din_q;
      mem_re_d      = 1'b0;
      mem_we_d      = 1'b0;

      case (state_q)
         StIdle: begin
            if (reqValid && req_ready_q) begin
               resp_rdata_d = '0;
               if (req_err) begin
                  // Errors never touch memory.
                  state_d      = StResp;
                  resp_error_d = 1'b1;
               end else begin
                  resp_error_d  = 1'b0;
                  mem_address_d = word_idx;
                  if (reqWrite) begin
                     state_d   = StWrite;
                     mem_we_d  = 1'b1;
                     mem_din_d = reqWData;
                  end else begin
                     state_d  = StRead;
                     mem_re_d = 1'b1;
                     cnt_d    = 4'(READ_LATENCY);
                  end
               end
            end
         end
         StRead: begin
            if (cnt_q <= 4'd1) begin
               state_d      = StResp;
               resp_rdata_d = memDataOut;
            end else begin
               cnt_d    = cnt_q - 4'd1;
               mem_re_d = 1'b1;
            end
         end
         StWrite: begin
            state_d = StResp;
         end
         StResp: begin
            if (respReady) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      req_ready_d  = (state_d == StIdle);
      resp_valid_d = (state_d == StResp);
      busy_d       = (state_d != StIdle);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         req_ready_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= '0;
         resp_error_q  <= 1'b0;
         mem_address_q <= '0;
         mem_re_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_din_q     <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_error_q  <= resp_error_d;
         mem_address_q <= mem_address_d;
         mem_re_q      <= mem_re_d;
         mem_we_q      <= mem_we_d;
         mem_din_q     <= mem_din_d;
         busy_q        <= busy_d;
      end
   end

   assign reqReady       = req_ready_q;
   assign respValid      = resp_valid_q;
   assign respRData      = resp_rdata_q;
   assign respError      = resp_error_q;
   assign memAddress     = mem_address_q;
   assign memReadEnable  = mem_re_q;
   assign memWriteEnable = mem_we_q;
   assign memDataIn      = mem_din_q;
   assign busy           = busy_q;

endmodule
